sram_write_monitor: RTL and testbench
=====================================

// Module: sram_write_monitor
// PURPOSE
//  Synthesizable, parametrised monitor of the external SRAM write port.
//  Classifies each write into one of NUM_REGIONS address regions and keeps per-region
//  statistics: write count, data checksum, order errors and completion.
//  Counts writes that fall outside every region or arrive after completion.
//  Sits beside the SRAM mux in project; rd_* taps go to the seven-seg/UART debug path for on-board self-check.
// PARAMETERS
//  ADDR_W      18  SRAM word-address width
//  DATA_W      16  SRAM data width
//  NUM_REGIONS 3   number of monitored regions (1..8)
//  SUM_W       32  checksum accumulator width (>= DATA_W)
//  ERR_W       8   width of every error counter (saturating)
//  SEQ_CHECK   1   1: flag writes that are not at the expected next address of their region
// PORTS
//  Clock_50        in   1                   system clock
//  Reset           in   1                   synchronous, active-high reset
//  start           in   1                   1-cycle pulse: clear statistics and arm
//  region_base     in   NUM_REGIONS*ADDR_W  region i base = [i*ADDR_W +: ADDR_W]
//  region_size     in   NUM_REGIONS*ADDR_W  region i word count; sampled on start
//  SRAM_address    in   ADDR_W              address driven to SRAM
//  SRAM_write_data in   DATA_W              write data driven to SRAM
//  SRAM_we_n       in   1                   active-low write enable
//  rd_sel          in   3                   region select for rd_* outputs
//  rd_count        out  ADDR_W              writes seen in region rd_sel (saturating)
//  rd_sum          out  SUM_W               checksum of region rd_sel
//  rd_order_err    out  ERR_W               order errors in region rd_sel
//  rd_done         out  1                   region rd_sel reached its size
//  oor_count       out  ERR_W               writes outside all regions
//  late_count      out  ERR_W               writes accepted while in S_DONE
//  first_oor_addr  out  ADDR_W              address of first out-of-region write
//  armed           out  1                   state == S_ARMED
//  all_done        out  1                   state == S_DONE
// BEHAVIOUR
//  - Reset: state S_IDLE; all counters, sums and first_oor_addr = 0; armed = all_done = 0; region bases/sizes = 0.
//  - FSM: S_IDLE -start-> S_ARMED; S_ARMED -every region done-> S_DONE; S_DONE -start-> S_ARMED.
//    start in any state clears statistics and re-arms (restart mid-frame allowed).
//  - start and a write in the same cycle: clear wins; the write is NOT counted.
//  - On start, region_base and region_size are latched; expected_next[i] = base[i].
//    Region i with size 0 is done immediately. If all sizes are 0, go to S_DONE on the next cycle.
//  - Write event = (SRAM_we_n == 0) in S_ARMED or S_DONE. Inputs are registered once;
//    statistics update 2 cycles after the write cycle. Latency is fixed and no event is ever dropped.
//    Back-to-back writes every cycle are supported.
//  - Region hit: base <= addr < base+size, computed at ADDR_W+1 bits; no wrap past 2^ADDR_W.
//    Overlapping regions: the lowest index wins; a write is counted in one region only.
//  - Hit in region i (S_ARMED):
//      count += 1, saturates at all-ones;
//      sum = {sum[SUM_W-2:0], sum[SUM_W-1]} + zero-extended data, modulo 2^SUM_W.
//    If SEQ_CHECK and addr != expected_next[i]: order_err += 1 (saturating).
//    In all cases expected_next[i] = addr + 1.
//  - done[i] sets when count == size and stays set. Further hits in region i still count;
//    each one also increments order_err[i] as an overrun.
//  - Miss on every region: oor_count += 1 (saturating). first_oor_addr is captured only on the first miss after start.
//  - Any write in S_DONE: late_count += 1 only. Region statistics and oor_count are frozen.
//  - S_ARMED -> S_DONE occurs on the cycle after the final done[i] sets.
//  - rd_sel >= NUM_REGIONS: rd_* read 0. rd_* are combinational from registered state.
//  - Writes in S_IDLE are ignored.
// TESTING
//  - Reset with SRAM_we_n = 0 held -> all outputs 0, state S_IDLE, no counting.
//  - 3 regions (base 0/38400/57600, sizes 38400/19200/19200); write every address once
//    in order with data = addr[15:0] -> counts match sizes, order_err = 0, all_done = 1;
//    rd_sum matches the bench model.
//  - Region 0 size 4, writes to 0,1,3,2 -> rd_order_err = 2, rd_done = 1.
//  - Write to 146945 outside all regions, then to 200000 -> oor_count = 2, first_oor_addr = 146945.
//  - 300 out-of-region writes -> oor_count saturates at 255. After done, one more write ->
//    late_count = 1 and region count unchanged.
//  - start asserted together with a write mid-frame -> all counters 0, the write is not counted,
//    armed = 1 on the next cycle.

Source files
------------

// File: rtl/sram_write_monitor.sv
// SRAM write-port monitor: sorts each write into one of NUM_REGIONS address windows
// and keeps per-region count/checksum/order statistics plus out-of-region and late counters.
module sram_write_monitor #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int NUM_REGIONS = 3,
  parameter int SUM_W       = 32,
  parameter int ERR_W       = 8,
  parameter int SEQ_CHECK   = 1
) (
  input  logic                          Clock_50,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_size,
  input  logic [ADDR_W-1:0]             SRAM_address,
  input  logic [DATA_W-1:0]             SRAM_write_data,
  input  logic                          SRAM_we_n,
  input  logic [2:0]                    rd_sel,
  output logic [ADDR_W-1:0]             rd_count,
  output logic [SUM_W-1:0]              rd_sum,
  output logic [ERR_W-1:0]              rd_order_err,
  output logic                          rd_done,
  output logic [ERR_W-1:0]              oor_count,
  output logic [ERR_W-1:0]              late_count,
  output logic [ADDR_W-1:0]             first_oor_addr,
  output logic                          armed,
  output logic                          all_done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_DONE = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic                                r_ev_vld, r_ev_late;
  logic [ADDR_W-1:0]                   r_ev_addr;
  logic [DATA_W-1:0]                   r_ev_data;
  logic [NUM_REGIONS-1:0]              w_hit, w_sel, w_done;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  w_count;
  logic [NUM_REGIONS-1:0][SUM_W-1:0]   w_sum;
  logic [NUM_REGIONS-1:0][ERR_W-1:0]   w_err;
  logic                                w_arm_ev;
  logic [ERR_W-1:0]                    r_oor, r_late;
  logic [ADDR_W-1:0]                   r_first_oor;

  always_ff @(posedge Clock_50) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ARMED;
      S_ARMED: if (start) w_state_nxt = S_ARMED;
               else if (&w_done) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_ARMED;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Event register; a write coinciding with start is dropped so the clear wins.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      r_ev_vld  <= 1'b0;
      r_ev_late <= 1'b0;
      r_ev_addr <= '0;
      r_ev_data <= '0;
    end else begin
      r_ev_vld  <= !SRAM_we_n && !start && (r_state == S_ARMED || r_state == S_DONE);
      r_ev_late <= (r_state == S_DONE);
      r_ev_addr <= SRAM_address;
      r_ev_data <= SRAM_write_data;
    end
  end

  // Lowest-index hit owns the write when regions overlap.
  assign w_sel    = w_hit & ~(w_hit - NUM_REGIONS'(1));
  assign w_arm_ev = r_ev_vld && !r_ev_late;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    logic [ADDR_W-1:0] r_base, r_size, r_count, r_exp;
    logic [SUM_W-1:0]  r_sum;
    logic [ERR_W-1:0]  r_err;
    logic              r_done;
    logic [ADDR_W:0]   w_lo, w_hi, w_addr_x;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ERR_W:0]    w_err_sum;
    logic              w_ooo, w_upd;

    assign w_lo      = {1'b0, r_base};
    assign w_hi      = w_lo + {1'b0, r_size};
    assign w_addr_x  = {1'b0, r_ev_addr};
    assign w_hit[g]  = (w_addr_x >= w_lo) && (w_addr_x < w_hi);
    assign w_upd     = w_arm_ev && w_sel[g];
    assign w_ooo     = (SEQ_CHECK != 0) && (r_ev_addr != r_exp);
    assign w_cnt_nxt = (&r_count) ? r_count : r_count + ADDR_W'(1);
    // Out-of-order and overrun are independent faults, each worth one error.
    assign w_err_sum = {1'b0, r_err} + (ERR_W+1)'(w_ooo) + (ERR_W+1)'(r_done);

    always_ff @(posedge Clock_50) begin
      if (Reset) begin
        r_base  <= '0;
        r_size  <= '0;
        r_count <= '0;
        r_exp   <= '0;
        r_sum   <= '0;
        r_err   <= '0;
        r_done  <= 1'b0;
      end else if (start) begin
        r_base  <= region_base[g*ADDR_W +: ADDR_W];
        r_size  <= region_size[g*ADDR_W +: ADDR_W];
        r_exp   <= region_base[g*ADDR_W +: ADDR_W];
        r_count <= '0;
        r_sum   <= '0;
        r_err   <= '0;
        r_done  <= (region_size[g*ADDR_W +: ADDR_W] == '0);
      end else if (w_upd) begin
        r_count <= w_cnt_nxt;
        r_sum   <= {r_sum[SUM_W-2:0], r_sum[SUM_W-1]} + SUM_W'(r_ev_data);
        r_err   <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
        r_exp   <= r_ev_addr + ADDR_W'(1);
        if (w_cnt_nxt == r_size) r_done <= 1'b1;
      end
    end

    assign w_count[g] = r_count;
    assign w_sum[g]   = r_sum;
    assign w_err[g]   = r_err;
    assign w_done[g]  = r_done;
  end

  always_ff @(posedge Clock_50) begin
    if (Reset || start) begin
      r_oor       <= '0;
      r_late      <= '0;
      r_first_oor <= '0;
    end else if (r_ev_vld) begin
      if (r_ev_late) begin
        if (!(&r_late)) r_late <= r_late + ERR_W'(1);
      end else if (w_hit == '0) begin
        if (!(&r_oor)) r_oor <= r_oor + ERR_W'(1);
        if (r_oor == '0) r_first_oor <= r_ev_addr;
      end
    end
  end

  always_comb begin
    rd_count     = '0;
    rd_sum       = '0;
    rd_order_err = '0;
    rd_done      = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (rd_sel == 3'(i)) begin
        rd_count     = w_count[i];
        rd_sum       = w_sum[i];
        rd_order_err = w_err[i];
        rd_done      = w_done[i];
      end
    end
  end

  assign oor_count      = r_oor;
  assign late_count     = r_late;
  assign first_oor_addr = r_first_oor;
  assign armed          = (r_state == S_ARMED);
  assign all_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_sram_write_monitor.sv
// Self-checking bench for sram_write_monitor: directed frames plus randomized traffic
// compared against a cycle-tagged behavioural model of the region statistics.
module tb_sram_write_monitor;
  localparam int AW = 18, DW = 16, NR = 3, SW = 32, EW = 8;
  localparam int unsigned ERR_MAX = 255;
  localparam int unsigned CNT_MAX = (1 << AW) - 1;
  localparam longint NEVER = 64'd1 << 40;

  logic              Clock_50 = 1'b0;
  logic              Reset, start, SRAM_we_n;
  logic [NR*AW-1:0]  region_base, region_size;
  logic [AW-1:0]     SRAM_address;
  logic [DW-1:0]     SRAM_write_data;
  logic [2:0]        rd_sel;
  logic [AW-1:0]     rd_count, first_oor_addr;
  logic [SW-1:0]     rd_sum;
  logic [EW-1:0]     rd_order_err, oor_count, late_count;
  logic              rd_done, armed, all_done;

  always #5 Clock_50 = ~Clock_50;

  sram_write_monitor dut (
    .Clock_50(Clock_50), .Reset(Reset), .start(start),
    .region_base(region_base), .region_size(region_size),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .rd_sel(rd_sel), .rd_count(rd_count), .rd_sum(rd_sum), .rd_order_err(rd_order_err),
    .rd_done(rd_done), .oor_count(oor_count), .late_count(late_count),
    .first_oor_addr(first_oor_addr), .armed(armed), .all_done(all_done)
  );

  int n_chk = 0, n_pass = 0;
  longint cyc = 0;

  // Behavioural model: writes applied in the cycle they are issued; the
  // cycle from which the monitor is DONE is tracked as a plain number.
  bit           m_started;
  longint       m_done_cyc;
  int unsigned  m_base[NR], m_size[NR], m_cnt[NR], m_err[NR], m_exp[NR];
  bit           m_rdone[NR];
  logic [31:0]  m_sum[NR];
  int unsigned  m_oor, m_late, m_first;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic model_reset();
    m_started = 0; m_done_cyc = NEVER; m_oor = 0; m_late = 0; m_first = 0;
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 0; m_size[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_exp[i] = 0;
      m_rdone[i] = 0; m_sum[i] = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit we, input int unsigned a, input int unsigned d);
    int hit;
    bit all0, alld;
    int unsigned e;
    if (st) begin
      all0 = 1;
      m_started = 1; m_oor = 0; m_late = 0; m_first = 0;
      for (int i = 0; i < NR; i++) begin
        m_base[i]  = region_base[i*AW +: AW];
        m_size[i]  = region_size[i*AW +: AW];
        m_cnt[i]   = 0; m_sum[i] = 0; m_err[i] = 0;
        m_exp[i]   = m_base[i];
        m_rdone[i] = (m_size[i] == 0);
        if (m_size[i] != 0) all0 = 0;
      end
      m_done_cyc = all0 ? cyc + 2 : NEVER;
      return;
    end
    if (!we || !m_started) return;
    if (cyc >= m_done_cyc) begin
      if (m_late < ERR_MAX) m_late++;
      return;
    end
    hit = -1;
    for (int i = 0; i < NR; i++)
      if (hit < 0 && a >= m_base[i] && a < m_base[i] + m_size[i]) hit = i;
    if (hit < 0) begin
      if (m_oor == 0) m_first = a;
      if (m_oor < ERR_MAX) m_oor++;
      return;
    end
    e = m_err[hit] + ((a != m_exp[hit]) ? 1 : 0) + (m_rdone[hit] ? 1 : 0);
    m_err[hit] = (e > ERR_MAX) ? ERR_MAX : e;
    m_sum[hit] = {m_sum[hit][30:0], m_sum[hit][31]} + (d & 32'hFFFF);
    if (m_cnt[hit] < CNT_MAX) m_cnt[hit]++;
    m_exp[hit] = (a + 1) % (1 << AW);
    if (m_cnt[hit] == m_size[hit]) m_rdone[hit] = 1;
    alld = 1;
    for (int i = 0; i < NR; i++) if (!m_rdone[i]) alld = 0;
    if (alld && m_done_cyc == NEVER) m_done_cyc = cyc + 3;
  endtask

  task automatic drive(input bit st, input bit we, input int unsigned a, input int unsigned d);
    start = st; SRAM_we_n = !we; SRAM_address = AW'(a); SRAM_write_data = DW'(d);
    model_step(st, we, a, d);
    @(posedge Clock_50); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0);
  endtask

  task automatic set_reg(input int idx, input int unsigned b, input int unsigned s);
    region_base[idx*AW +: AW] = AW'(b);
    region_size[idx*AW +: AW] = AW'(s);
  endtask

  task automatic check_all(input string tag);
    int oob[2];
    oob[0] = 3; oob[1] = 7;
    for (int i = 0; i < NR; i++) begin
      rd_sel = 3'(i); #1;
      chk($sformatf("%s.cnt%0d", tag, i),  32'(rd_count),     m_cnt[i]);
      chk($sformatf("%s.sum%0d", tag, i),  rd_sum,            m_sum[i]);
      chk($sformatf("%s.err%0d", tag, i),  32'(rd_order_err), m_err[i]);
      chk($sformatf("%s.done%0d", tag, i), 32'(rd_done),      32'(m_rdone[i]));
    end
    for (int j = 0; j < 2; j++) begin
      rd_sel = 3'(oob[j]); #1;
      chk($sformatf("%s.oob_cnt%0d", tag, oob[j]), 32'(rd_count), 0);
      chk($sformatf("%s.oob_sum%0d", tag, oob[j]), rd_sum, 0);
      chk($sformatf("%s.oob_err%0d", tag, oob[j]), 32'(rd_order_err), 0);
      chk($sformatf("%s.oob_done%0d", tag, oob[j]), 32'(rd_done), 0);
    end
    chk({tag, ".oor"},   32'(oor_count),      m_oor);
    chk({tag, ".late"},  32'(late_count),     m_late);
    chk({tag, ".first"}, 32'(first_oor_addr), m_first);
    chk({tag, ".armed"}, 32'(armed),    32'(m_started && cyc < m_done_cyc));
    chk({tag, ".adone"}, 32'(all_done), 32'(m_started && cyc >= m_done_cyc));
  endtask

  initial begin
    bit st, we;
    int unsigned a;
    int r;
    Reset = 1; start = 0; SRAM_we_n = 0; SRAM_address = 5; SRAM_write_data = 16'hA5A5;
    region_base = '0; region_size = '0; rd_sel = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock_50); #1; cyc++;
      SRAM_address = SRAM_address + AW'(1);
    end
    check_all("rst");
    Reset = 0;
    for (int k = 0; k < 4; k++) drive(0, 1, 100 + k, k);
    idle(3);
    check_all("idle");

    // Full frame, every address once in order.
    set_reg(0, 0, 38400); set_reg(1, 38400, 19200); set_reg(2, 57600, 19200);
    drive(1, 0, 0, 0);
    for (int unsigned k = 0; k < 76800; k++) drive(0, 1, k, k & 16'hFFFF);
    idle(3);
    check_all("frame");
    rd_sel = 0; #1; chk("frame.size0", 32'(rd_count), 38400);
    rd_sel = 2; #1; chk("frame.size2", 32'(rd_count), 19200);
    chk("frame.err2", 32'(rd_order_err), 0);
    chk("frame.all_done", 32'(all_done), 1);

    // Out-of-order writes in a 4-word region.
    set_reg(0, 0, 4); set_reg(1, 0, 0); set_reg(2, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 11); drive(0, 1, 1, 22); drive(0, 1, 3, 33); drive(0, 1, 2, 44);
    idle(3);
    check_all("order");
    rd_sel = 0; #1;
    chk("order.err", 32'(rd_order_err), 2);
    chk("order.done", 32'(rd_done), 1);

    // Two out-of-region writes.
    set_reg(0, 0, 100); set_reg(1, 1000, 100); set_reg(2, 2000, 100);
    drive(1, 0, 0, 0);
    drive(0, 1, 146945, 1); drive(0, 1, 200000, 2);
    idle(3);
    check_all("oor");
    chk("oor.count", 32'(oor_count), 2);
    chk("oor.first", 32'(first_oor_addr), 146945);

    // Saturating oor counter, then a late write after completion.
    set_reg(0, 0, 2); set_reg(1, 10, 1); set_reg(2, 20, 1);
    drive(1, 0, 0, 0);
    for (int k = 0; k < 300; k++) drive(0, 1, 5000 + k, k);
    drive(0, 1, 0, 7); drive(0, 1, 1, 8); drive(0, 1, 10, 9); drive(0, 1, 20, 10);
    idle(3);
    chk("sat.all_done", 32'(all_done), 1);
    drive(0, 1, 0, 99);
    idle(3);
    check_all("sat");
    chk("sat.oor", 32'(oor_count), 255);
    chk("sat.late", 32'(late_count), 1);
    rd_sel = 0; #1; chk("sat.cnt0", 32'(rd_count), 2);

    // Restart together with a write mid-frame.
    set_reg(0, 0, 50); set_reg(1, 100, 50); set_reg(2, 200, 50);
    drive(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive(0, 1, k, k);
    drive(1, 1, 10, 10);
    rd_sel = 0; #1;
    chk("rst_mid.armed", 32'(armed), 1);
    chk("rst_mid.cnt0", 32'(rd_count), 0);
    idle(3);
    check_all("rst_mid");
    for (int k = 0; k < 5; k++) drive(0, 1, k, k + 3);
    idle(3);
    check_all("rst_mid2");

    // Randomized frames with occasional restarts and region-input churn.
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NR; i++) set_reg(i, $urandom_range(0, 300), $urandom_range(0, 12));
      drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, 340), $urandom);
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 19) == 0)
          set_reg($urandom_range(0, NR-1), $urandom_range(0, 300), $urandom_range(0, 12));
        st = ($urandom_range(0, 99) == 0);
        we = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, NR-1);
          a = m_exp[r];
        end else a = $urandom_range(0, 340);
        drive(st, we, a, $urandom);
      end
      idle(3);
      check_all($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
